subsecond_stopwatch: RTL and testbench



---
 rtl/subsecond_stopwatch.sv | 172 +++++++++++++++++
 tb/tb_subsecond_stopwatch.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/subsecond_stopwatch.sv
// -----------------------------------------------------------------------------
// subsecond_stopwatch
//   Free-running 0.1 s stopwatch counting 00.0 .. 59.9 s, then wrapping to 00.0.
//   An internal divider turns clk into a one-cycle tick every CLK_HZ/TICK_HZ
//   cycles. A BCD chain (tenths ds, seconds ss, tens ts) advances on each tick.
//   Seconds are shown on two active-low 7-segment digits through display
//   registers that freeze while pause=1 (split/lap). Counting continues
//   underneath. Tenths are shown on a one-hot 10-LED bar.
//
// Parameters
//   CLK_HZ   input clock frequency in Hz
//   TICK_HZ  count rate in Hz; CLK_HZ/TICK_HZ must be an integer >= 2
//
// Ports
//   clk    in   1   sole clock, rising edge
//   reset  in   1   synchronous active-high clear of all state
//   pause  in   1   1 = hold displayed seconds, 0 = display tracks counter
//   left   out  7   tens-of-seconds digit, {g,f,e,d,c,b,a}, active-low
//   right  out  7   units-of-seconds digit, same encoding
//   side   out  10  one-hot tenths bar, side[d]=1 for tenths digit d
//
// Configuration macro
//   FREEZE_SIDE_EN  when defined, the tenths bar also comes from a display
//                   register (pds), so it freezes under pause like the digits.
// -----------------------------------------------------------------------------

package subsecond_stopwatch_pkg;

  // Active-low {g,f,e,d,c,b,a} decode; codes 10..15 blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h40;
      4'd1:    pattern = 7'h79;
      4'd2:    pattern = 7'h24;
      4'd3:    pattern = 7'h30;
      4'd4:    pattern = 7'h19;
      4'd5:    pattern = 7'h12;
      4'd6:    pattern = 7'h02;
      4'd7:    pattern = 7'h78;
      4'd8:    pattern = 7'h00;
      4'd9:    pattern = 7'h10;
      default: pattern = 7'h7F;
    endcase
    return pattern;
  endfunction

endpackage

module subsecond_stopwatch
  import subsecond_stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  output logic [6:0] left,
  output logic [6:0] right,
  output logic [9:0] side
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       ds_q, ds_d;
  logic [3:0]       ss_q, ss_d;
  logic [2:0]       ts_q, ts_d;
  logic [2:0]       pts_q, pts_d;
  logic [3:0]       pss_q, pss_d;
  logic             tick_s;
`ifdef FREEZE_SIDE_EN
  logic [3:0]       pds_q, pds_d;
`endif

  // Divider: tick on the last count of each DIV-cycle period, then wrap to 0.
  always_comb begin
    tick_s = (div_q == DIV_W'(DIV - 1));
    if (tick_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // BCD chain: each stage wraps and carries into the next only on a tick.
  always_comb begin
    ds_d = ds_q;
    ss_d = ss_q;
    ts_d = ts_q;
    if (tick_s) begin
      if (ds_q >= 4'd9) begin
        ds_d = 4'd0;
        if (ss_q >= 4'd9) begin
          ss_d = 4'd0;
          if (ts_q >= 3'd5) begin
            ts_d = 3'd0;
          end else begin
            ts_d = ts_q + 3'd1;
          end
        end else begin
          ss_d = ss_q + 4'd1;
        end
      end else begin
        ds_d = ds_q + 4'd1;
      end
    end else begin
      ds_d = ds_q;
    end
  end

  // Display registers: level-sensitive load of the live count while not paused.
  always_comb begin
    if (pause) begin
      pts_d = pts_q;
      pss_d = pss_q;
    end else begin
      pts_d = ts_q;
      pss_d = ss_q;
    end
  end

`ifdef FREEZE_SIDE_EN
  // Tenths display register, frozen together with the seconds digits.
  always_comb begin
    if (pause) begin
      pds_d = pds_q;
    end else begin
      pds_d = ds_q;
    end
  end
`endif

  // State registers with synchronous clear; reset wins over pause and tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      ds_q  <= 4'd0;
      ss_q  <= 4'd0;
      ts_q  <= 3'd0;
      pts_q <= 3'd0;
      pss_q <= 4'd0;
`ifdef FREEZE_SIDE_EN
      pds_q <= 4'd0;
`endif
    end else begin
      div_q <= div_d;
      ds_q  <= ds_d;
      ss_q  <= ss_d;
      ts_q  <= ts_d;
      pts_q <= pts_d;
      pss_q <= pss_d;
`ifdef FREEZE_SIDE_EN
      pds_q <= pds_d;
`endif
    end
  end

  // Output decode straight from registered state.
  always_comb begin
    left  = seg7({1'b0, pts_q});
    right = seg7(pss_q);
`ifdef FREEZE_SIDE_EN
    side  = 10'd1 << pds_q;
`else
    side  = 10'd1 << ds_q;
`endif
  end

endmodule

// File: tb/tb_subsecond_stopwatch.sv
// -----------------------------------------------------------------------------
// tb_subsecond_stopwatch
//   Self-checking bench for subsecond_stopwatch with CLK_HZ=100, TICK_HZ=10
//   (DIV=10). A cycle model pushes the expected {left,right,side} into a
//   scoreboard queue at every driven edge; the entry is popped and compared
//   1 time unit after that edge. Directed spot checks cover the reset state,
//   tick latency, the 59.9 -> 00.0 wrap, pause/release and the digit table.
// -----------------------------------------------------------------------------
module tb_subsecond_stopwatch;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       pause;
  logic [6:0] left;
  logic [6:0] right;
  logic [9:0] side;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0] l;
    logic [6:0] r;
    logic [9:0] s;
  } exp_t;

  exp_t sb_q[$];

  // Bench-side reference state
  int m_div, m_ds, m_ss, m_ts, m_pts, m_pss, m_pds;

  subsecond_stopwatch #(
    .CLK_HZ (100),
    .TICK_HZ(10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .pause(pause),
    .left (left),
    .right(right),
    .side (side)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0:       return 7'h40;
      1:       return 7'h79;
      2:       return 7'h24;
      3:       return 7'h30;
      4:       return 7'h19;
      5:       return 7'h12;
      6:       return 7'h02;
      7:       return 7'h78;
      8:       return 7'h00;
      9:       return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the reference model across one rising edge using current inputs.
  task automatic model_edge();
    bit tick;
    int o_ds, o_ss, o_ts;
    exp_t e;
    o_ds = m_ds; o_ss = m_ss; o_ts = m_ts;
    if (reset) begin
      m_div = 0; m_ds = 0; m_ss = 0; m_ts = 0;
      m_pts = 0; m_pss = 0; m_pds = 0;
    end else begin
      tick = (m_div == DIV - 1);
      m_div = tick ? 0 : m_div + 1;
      if (tick) begin
        if (o_ds == 9) begin
          m_ds = 0;
          if (o_ss == 9) begin
            m_ss = 0;
            m_ts = (o_ts == 5) ? 0 : o_ts + 1;
          end else begin
            m_ss = o_ss + 1;
          end
        end else begin
          m_ds = o_ds + 1;
        end
      end
      if (!pause) begin
        m_pts = o_ts; m_pss = o_ss; m_pds = o_ds;
      end
    end
    e.l = ref_seg(m_pts);
    e.r = ref_seg(m_pss);
`ifdef FREEZE_SIDE_EN
    e.s = 10'd1 << m_pds;
`else
    e.s = 10'd1 << m_ds;
`endif
    sb_q.push_back(e);
  endtask

  // One clock: model + push at the edge, pop + compare 1 unit later.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val("sb_left", left, e.l);
      check_val("sb_right", right, e.r);
      check_val("sb_side", side, e.s);
    end
  endtask

  task automatic run(input int n, input logic r, input logic p);
    reset = r;
    pause = p;
    repeat (n) cycle();
  endtask

  task automatic spot(input string tag, input logic [6:0] l, input logic [6:0] r, input logic [9:0] s);
    check_val({tag, "_left"}, left, l);
    check_val({tag, "_right"}, right, r);
    check_val({tag, "_side"}, side, s);
  endtask

  initial begin
    reset = 1'b1;
    pause = 1'b0;

    // 1: reset state and first tick exactly 10 cycles later
    run(1, 1'b1, 1'b0);
    spot("rst", 7'h40, 7'h40, 10'h001);
    run(9, 1'b0, 1'b0);
    check_val("pre_tick_side", side, 10'h001);
    run(1, 1'b0, 1'b0);
    check_val("first_tick_side", side, 10'h002);

    // 2: one second elapsed, digit visible one edge after the tick
    run(90, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0);
    spot("one_sec", 7'h40, 7'h79, 10'h001);

    // 3: 599 ticks from reset -> 59.9, then full wrap to 00.0
    run(1, 1'b1, 1'b0);
    run(5991, 1'b0, 1'b0);
    spot("t59_9", 7'h12, 7'h10, 10'h200);
    run(10, 1'b0, 1'b0);
    spot("wrap", 7'h40, 7'h40, 10'h001);

    // 4: pause at 3.4 s for 25 ticks, then release
    run(1, 1'b1, 1'b0);
    run(340, 1'b0, 1'b0);
    spot("t3_4", 7'h40, 7'h30, 10'h010);
    run(250, 1'b0, 1'b1);
`ifdef FREEZE_SIDE_EN
    spot("paused", 7'h40, 7'h30, 10'h010);
`else
    spot("paused", 7'h40, 7'h30, 10'h200);
`endif
    run(1, 1'b0, 1'b0);
    spot("released", 7'h40, 7'h12, 10'h200);

    // 5: reset mid-count while paused
    run(37, 1'b0, 1'b1);
    run(1, 1'b1, 1'b1);
    spot("rst_paused", 7'h40, 7'h40, 10'h001);
    run(25, 1'b0, 1'b0);

    // 6: digit decode table, including blank codes
    for (int i = 0; i < 16; i++) begin
      check_val($sformatf("seg%0d", i), subsecond_stopwatch_pkg::seg7(4'(i)), ref_seg(i));
    end

    check_val("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
